ser_frame_ctrl: RTL and testbench

- Sequencing controller for the lab's serial datapath.
- Hunts for a sync pattern on ser_in, captures a length field, then forwards exactly that many payload bits to ser_out with a valid strobe.
- Exposes the remaining-bit count for the hex display.
- Advances only on step strobes (clk_en) from the one-pulser, so a board button or an auto strobe steps the frame one bit at a time.

---
 rtl/ser_pkg.sv | 17 +
 rtl/sync_matcher.sv | 36 +++
 rtl/ser_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ser_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial frame controller: FSM state encoding and
// default sync/length sizing (also used to size the hex display).
package ser_pkg;

    localparam int unsigned SER_SYNC_W = 3;
    localparam logic [SER_SYNC_W-1:0] SER_SYNC_PAT = 3'b110;
    localparam int unsigned SER_LEN_W = 4;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        DONE = 3'd4
    } ser_state_e;

endpackage

// File: rtl/sync_matcher.sv
// Sync pattern detector: shift register of recent ser_in bits plus a
// comparator that looks at the history together with the bit on the wire now,
// so a match is reported on the strobe that completes the pattern.
module sync_matcher
    import ser_pkg::*;
#(
    parameter int unsigned               SYNC_W   = SER_SYNC_W,
    parameter logic [SYNC_W-1:0]         SYNC_PAT = SER_SYNC_PAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_shift,
    input  logic i_clr,
    input  logic i_bit,
    output logic o_match
);

    // Only the newest SYNC_W-1 bits can ever reach the comparator again.
    logic [SYNC_W-2:0] r_sr;
    logic [SYNC_W-1:0] w_window;

    assign w_window = {r_sr, i_bit};
    assign o_match  = (w_window == SYNC_PAT);

    // History register: cleared on request, otherwise shifts on each hunt strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= w_window[SYNC_W-2:0];
        end
    end

endmodule

// File: rtl/ser_frame_ctrl.sv
// Serial frame sequencer: hunts for the sync pattern, captures an LSB-first
// length field, then forwards that many payload bits with a valid strobe.
// Everything advances only on clk_en step strobes.
// Optional feature: define SER_PARITY_EN to check one even-parity bit after
// the payload and report a mismatch on err; otherwise err is tied low.
module ser_frame_ctrl
    import ser_pkg::*;
#(
    parameter int unsigned       SYNC_W   = SER_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SER_SYNC_PAT,
    parameter int unsigned       LEN_W    = SER_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic [LEN_W-1:0] cnt_out,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam logic [LEN_W-1:0] LAST_LEN_BIT = LEN_W'(LEN_W - 1);

    ser_state_e       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bit_cnt;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ser_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_len_next;
    logic             w_match;
    logic             w_shift;
    logic             w_clr;

    // Length register with the current bit merged in at its LSB-first position.
    assign w_len_next = r_len | (LEN_W'(ser_in) << r_bit_cnt);

    // The DONE strobe's bit is dropped and the history starts from zero.
    assign w_shift = clk_en && (r_state == HUNT);
    assign w_clr   = clk_en && (r_state == DONE);

    sync_matcher #(
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_sync_matcher (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_shift),
        .i_clr   (w_clr),
        .i_bit   (ser_in),
        .o_match (w_match)
    );

`ifdef SER_PARITY_EN
    logic r_par;
    logic r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Frame FSM with registered outputs; pulses self-clear on every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= HUNT;
            r_len     <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_ser_out <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SER_PARITY_EN
            r_par     <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (clk_en) begin
                case (r_state)
                    HUNT: begin
                        if (w_match) begin
                            r_state   <= LEN;
                            r_bit_cnt <= '0;
                            r_len     <= '0;
                            r_busy    <= 1'b1;
`ifdef SER_PARITY_EN
                            r_par     <= 1'b0;
                            r_err     <= 1'b0;
`endif
                        end
                    end
                    LEN: begin
                        r_len     <= w_len_next;
                        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                        if (r_bit_cnt == LAST_LEN_BIT) begin
                            if (w_len_next == '0) begin
`ifdef SER_PARITY_EN
                                r_state <= PAR;
`else
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
`endif
                            end else begin
                                r_state <= DATA;
                                r_cnt   <= w_len_next;
                            end
                        end
                    end
                    DATA: begin
                        r_ser_out <= ser_in;
                        r_valid   <= 1'b1;
                        r_cnt     <= r_cnt - LEN_W'(1);
`ifdef SER_PARITY_EN
                        r_par     <= r_par ^ ser_in;
`endif
                        if (r_cnt <= LEN_W'(1)) begin
`ifdef SER_PARITY_EN
                            r_state <= PAR;
`else
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
`endif
                        end
                    end
`ifdef SER_PARITY_EN
                    PAR: begin
                        r_err   <= ser_in ^ r_par;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
`endif
                    DONE: begin
                        r_state <= HUNT;
                    end
                    default: begin
                        r_state <= HUNT;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign ser_out       = r_ser_out;
    assign ser_out_valid = r_valid;
    assign cnt_out       = r_cnt;
    assign busy          = r_busy;
    assign frame_done    = r_done;

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Self-checking bench for ser_frame_ctrl: frames are built from random or
// directed bit sequences and every output is predicted from the frame itself.
module tb_ser_frame_ctrl;
    import ser_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 clk_en;
    logic                 ser_in;
    logic                 ser_out;
    logic                 ser_out_valid;
    logic [SER_LEN_W-1:0] cnt_out;
    logic                 busy;
    logic                 frame_done;
    logic                 err;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_valid   = 0;
    int n_done    = 0;
    int exp_valid = 0;
    int exp_done  = 0;

    ser_frame_ctrl #(
        .SYNC_W   (SER_SYNC_W),
        .SYNC_PAT (SER_SYNC_PAT),
        .LEN_W    (SER_LEN_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .ser_in        (ser_in),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .cnt_out       (cnt_out),
        .busy          (busy),
        .frame_done    (frame_done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters: each pulse lasts one full cycle, so one negedge sees it.
    always @(negedge clk) begin
        if (ser_out_valid) n_valid++;
        if (frame_done)    n_done++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One step strobe; returns 1 time unit after the consuming edge.
    task automatic strobe(input logic b);
        ser_in = b;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        ser_in = 1'($urandom);
    endtask

    // Idle clocks: no pulses and nothing may move.
    task automatic idle(input int n);
        logic [SER_LEN_W-1:0] c;
        logic b;
        logic so;
        logic e;
        c  = cnt_out;
        b  = busy;
        so = ser_out;
        e  = err;
        clk_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ser_in = 1'($urandom);
            check_eq("idle_valid", ser_out_valid, 0);
            check_eq("idle_done", frame_done, 0);
            check_eq("idle_cnt", cnt_out, c);
            check_eq("idle_busy", busy, b);
            check_eq("idle_ser_out", ser_out, so);
            check_eq("idle_err", err, e);
        end
    endtask

    function automatic int pick_gap(input int gmode);
        return (gmode < 0) ? int'($urandom_range(0, 3)) : gmode;
    endfunction

    // Whole frame: hunt (hn>0: fixed bits hs, MSB sent first; hn==0: random),
    // length field, payload pl (bit 0 first), optional parity, DONE strobe.
    task automatic run_frame(input int len, input logic [14:0] pl, input int hn,
                             input logic [7:0] hs, input int gmode, input logic par_bad);
        logic q[$];
        logic [SER_SYNC_W-1:0] pat;
        logic [SER_LEN_W-1:0]  lbits;
        logic b;
        logic par;
        logic exp_err;
        bit   matched;
        pat     = SER_SYNC_PAT;
        lbits   = SER_LEN_W'(len);
        matched = 0;
        q.delete();

        for (int k = 0; k < 40 && !matched; k++) begin
            if (hn > 0) begin
                if (k >= hn) break;
                b = hs[hn-1-k];
            end else if (k < 32) begin
                b = 1'($urandom);
            end else begin
                b = pat[SER_SYNC_W-1-(k-32)];
            end
            idle(pick_gap(gmode));
            strobe(b);
            q.push_back(b);
            if (q.size() >= SER_SYNC_W) begin
                matched = 1;
                for (int j = 0; j < SER_SYNC_W; j++)
                    if (q[q.size()-SER_SYNC_W+j] != pat[SER_SYNC_W-1-j]) matched = 0;
            end
            check_eq(matched ? "hunt_busy_on" : "hunt_busy_off", busy, matched ? 1 : 0);
            check_eq("hunt_cnt", cnt_out, 0);
        end
        if (!matched) begin
            check_eq("hunt_match", 0, 1);
            return;
        end
        check_eq("len_err_clr", err, 0);

        for (int i = 0; i < SER_LEN_W; i++) begin
            idle(pick_gap(gmode));
            strobe(lbits[i]);
            check_eq("len_valid", ser_out_valid, 0);
            if (i < SER_LEN_W - 1) begin
                check_eq("len_cnt", cnt_out, 0);
                check_eq("len_busy", busy, 1);
            end else if (len == 0) begin
                check_eq("zlen_cnt", cnt_out, 0);
`ifdef SER_PARITY_EN
                check_eq("zlen_busy", busy, 1);
                check_eq("zlen_done", frame_done, 0);
`else
                check_eq("zlen_busy", busy, 0);
                check_eq("zlen_done", frame_done, 1);
`endif
            end else begin
                check_eq("len_cnt_load", cnt_out, len);
                check_eq("len_busy_last", busy, 1);
                check_eq("len_done", frame_done, 0);
            end
        end

        par = 1'b0;
        for (int i = 0; i < len; i++) begin
            par ^= pl[i];
            idle(pick_gap(gmode));
            strobe(pl[i]);
            check_eq("data_valid", ser_out_valid, 1);
            check_eq("data_bit", ser_out, pl[i]);
            check_eq("data_cnt", cnt_out, len - 1 - i);
            if (i == len - 1) begin
`ifdef SER_PARITY_EN
                check_eq("data_last_busy", busy, 1);
                check_eq("data_last_done", frame_done, 0);
`else
                check_eq("data_last_busy", busy, 0);
                check_eq("data_last_done", frame_done, 1);
`endif
            end else begin
                check_eq("data_busy", busy, 1);
                check_eq("data_done", frame_done, 0);
            end
        end

`ifdef SER_PARITY_EN
        exp_err = par_bad;
        idle(pick_gap(gmode));
        strobe(par ^ par_bad);
        check_eq("par_err", err, exp_err);
        check_eq("par_done", frame_done, 1);
        check_eq("par_busy", busy, 0);
        check_eq("par_valid", ser_out_valid, 0);
`else
        exp_err = 1'b0;
`endif
        exp_valid += len;
        exp_done  += 1;

        // A 1 here would complete an early sync if it leaked into the next hunt.
        idle(pick_gap(gmode));
        strobe(1'b1);
        check_eq("done_pulse_end", frame_done, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_cnt", cnt_out, 0);
        check_eq("done_valid", ser_out_valid, 0);
        check_eq("done_err_hold", err, exp_err);
    endtask

    initial begin
        rst    = 1'b0;
        clk_en = 1'b0;
        ser_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ser_out", ser_out, 0);
        check_eq("rst_valid", ser_out_valid, 0);
        check_eq("rst_cnt", cnt_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic frame: sync 110, len 3, payload 1,0,1.
        run_frame(3, 15'b101, 3, 8'b110, 0, 1'b0);
        // Zero-length frame.
        run_frame(0, 15'b0, 3, 8'b110, 1, 1'b0);
        // Overlapping sync 1,1,1,0 with 5 idle clocks between strobes.
        run_frame(2, 15'b10, 4, 8'b1110, 5, 1'b0);

        // Reset in the middle of a len=15 payload.
        strobe(1'b1); strobe(1'b1); strobe(1'b0);
        for (int i = 0; i < SER_LEN_W; i++) strobe(1'b1);
        strobe(1'b1);
        strobe(1'b1);
        exp_valid += 2;
        idle(1);
        check_eq("pre_rst_ser_out", ser_out, 1);
        check_eq("pre_rst_cnt", cnt_out, 13);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ser_out", ser_out, 0);
        check_eq("mid_rst_valid", ser_out_valid, 0);
        check_eq("mid_rst_cnt", cnt_out, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", frame_done, 0);
        check_eq("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        run_frame(5, 15'($urandom), 3, 8'b110, -1, 1'b0);

        // Back-to-back strobes across a full len=15 frame.
        run_frame(15, 15'($urandom), 3, 8'b110, 0, 1'b0);

        // Parity: payload 1,1 with a wrong then a correct parity bit.
        run_frame(2, 15'b11, 3, 8'b110, 0, 1'b1);
        run_frame(2, 15'b11, 3, 8'b110, 0, 1'b0);

        // Random frames: random hunt noise, length, payload, gaps and parity.
        for (int f = 0; f < 25; f++) begin
            run_frame(int'($urandom_range(0, 15)), 15'($urandom), 0, 8'b0, -1,
                      1'($urandom));
        end

        idle(2);
        check_eq("valid_total", n_valid, exp_valid);
        check_eq("done_total", n_done, exp_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
